fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Owns the architectural PC and sequences instruction fetch: issues one request at a time to
//   instruction memory, returns the instruction plus its PC to decode through a 1-entry buffer,
//   and applies branch/trap redirects, halt and resume. Sits between imem and decode; replaces
//   the free-running PC register.
// PARAMETERS
//   XLEN          32            PC / address width
//   RESET_VECTOR  32'h0000_0000 PC loaded on reset
//   TRAP_VECTOR   32'h0000_0100 PC loaded on trap_req
// PORTS
//   clk             in   1     clock, all state on posedge
//   rst_n           in   1     asynchronous, active-low reset
//   imem_req_valid  out  1     fetch request valid
//   imem_req_ready  in   1     imem accepts request
//   imem_req_addr   out  XLEN  fetch address (= pc)
//   imem_rsp_valid  in   1     response valid (exactly one per accepted request, >=1 cycle later)
//   imem_rsp_data   in   32    instruction word
//   inst_valid      out  1     instruction available to decode
//   inst_ready      in   1     decode consumes instruction
//   inst_data       out  32    instruction word
//   inst_pc         out  XLEN  PC of inst_data
//   branch_taken    in   1     redirect to branch_target
//   branch_target   in   XLEN  branch destination; bits [1:0] ignored (forced 0)
//   trap_req        in   1     redirect to TRAP_VECTOR; beats branch_taken
//   halt_req        in   1     stop fetching
//   resume          in   1     restart fetching from pc
//   halted          out  1     1 while in HALT
// BEHAVIOUR
//   Reset (async assert, sync to clk on release): pc=RESET_VECTOR, state=IDLE, imem_req_valid=0,
//     inst_valid=0, inst_data=0, inst_pc=0, halted=0, drop=0.
//   States: IDLE, REQ, WAIT, HALT. IDLE -> REQ unconditionally after one cycle.
//   REQ: imem_req_valid = !inst_valid | inst_ready (buffer free or draining this cycle).
//     valid&ready -> latch req_pc=pc, go WAIT. At most one request outstanding, ever.
//   WAIT: imem_req_valid=0. On imem_rsp_valid:
//     drop=1 -> discard word, drop<=0, go REQ (pc already redirected).
//     drop=0 -> buffer<= {rsp_data, req_pc}, inst_valid<=1, pc<=req_pc+4, go REQ (or HALT if halt pending).
//   Output buffer: inst_valid clears on inst_valid&inst_ready unless reloaded same cycle.
//     inst_data/inst_pc stable while inst_valid & !inst_ready.
//   Redirect (trap_req | branch_taken), any state, highest priority:
//     pc<=TRAP_VECTOR if trap_req else {branch_target[XLEN-1:2],2'b00}; inst_valid<=0 (flush).
//     In WAIT without same-cycle response: drop<=1. In WAIT with same-cycle response: word discarded,
//     go REQ. In REQ: request withdrawn/re-addressed next cycle (imem_req_addr may change only
//     on a cycle following a redirect). In HALT: pc updated, remain HALT.
//   Halt: halt_req in REQ (request not accepted this cycle) -> HALT. In WAIT -> halt_pend<=1; response
//     still delivered, then HALT. Halt and redirect same cycle: both apply.
//   HALT: halted=1, imem_req_valid=0, buffer still drains. resume -> REQ; halt_req has priority over resume.
//   Arithmetic: pc+4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0). No misalignment trap.
//   Reset mid-WAIT: state cleared; a late imem response after reset must be ignored by imem side.
// STRUCTURE
//   Package fetch_pkg: state enum (IDLE/REQ/WAIT/HALT), INST_W=32, PC_INC=4, default vectors.
//   Sub-module fetch_out_buf: 1-entry valid/ready buffer {data,pc} with flush input.
//   Top holds pc, req_pc, drop, halt_pend and FSM.
// TESTING
//   Reset, imem_req_ready=1, rsp 1 cycle later -> addrs 0x0,0x4,0x8; inst_pc matches; 1st req_valid cycle 2.
//   inst_ready=0 with buffer full -> imem_req_valid=0, inst_data/inst_pc held; release -> fetch resumes at +4.
//   branch_taken, target 0x1003, during WAIT -> in-flight rsp dropped, next addr 0x1000, inst_valid flushed.
//   trap_req and branch_taken same cycle -> next addr 0x100.
//   halt_req during WAIT -> rsp delivered, halted=1, no req; resume -> next addr = req_pc+4.
//   pc at 0xFFFF_FFFC fetched -> next addr 0x0; rst_n low mid-WAIT -> all outputs reset values asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned DEF_XLEN         = 32;
    localparam int unsigned INST_W           = 32;
    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch sequencer bus bundle: imem request/response, decode handoff and control.
interface fetch_if import fetch_pkg::*; #(
    parameter int unsigned XLEN = DEF_XLEN
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [XLEN-1:0]   inst_pc;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_target;
    logic              trap_req;
    logic              halt_req;
    logic              resume;
    logic              halted;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, halted,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  branch_taken, branch_target, trap_req, halt_req, resume
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, halted,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output branch_taken, branch_target, trap_req, halt_req, resume
    );

endinterface

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready buffer holding {instruction, pc} for decode; flush wins over load.
module fetch_out_buf import fetch_pkg::*; #(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic              i_ready,
    input  logic [INST_W-1:0] i_data,
    input  logic [XLEN-1:0]   i_pc,
    output logic              o_valid,
    output logic [INST_W-1:0] o_data,
    output logic [XLEN-1:0]   o_pc
);

    logic              r_valid;
    logic [INST_W-1:0] r_data;
    logic [XLEN-1:0]   r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC: one outstanding imem fetch at a time, redirects, halt/resume.
module fetch_sequencer import fetch_pkg::*; #(
    parameter int unsigned     XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR)
) (
    input logic    clk,
    input logic    rst_n,
    fetch_if.master bus
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_drop;
    logic            r_halt_pend;

    logic            w_redirect;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp;
    logic            w_load;
    logic            w_halt;
    logic            w_inst_valid;
    logic [1:0]      w_unused_tgt_lsb;

    assign w_unused_tgt_lsb = bus.branch_target[1:0];
    assign w_redirect       = bus.trap_req | bus.branch_taken;
    assign w_redirect_pc    = bus.trap_req ? TRAP_VECTOR
                                           : {bus.branch_target[XLEN-1:2], 2'b00};

    // Request only when the buffer is empty or being drained this cycle.
    assign w_req_valid = (r_state == ST_REQ) && (!w_inst_valid || bus.inst_ready);
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp       = (r_state == ST_WAIT) && bus.imem_rsp_valid;
    assign w_load      = w_rsp && !r_drop && !w_redirect;
    assign w_halt      = bus.halt_req || r_halt_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_VECTOR;
            r_req_pc    <= '0;
            r_drop      <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ: begin
                    if (w_req_fire) begin
                        // A redirect in the accept cycle makes the in-flight word stale.
                        r_req_pc    <= r_pc;
                        r_drop      <= w_redirect;
                        r_halt_pend <= bus.halt_req;
                        r_state     <= ST_WAIT;
                    end else if (bus.halt_req) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        r_drop      <= 1'b0;
                        r_halt_pend <= 1'b0;
                        r_state     <= w_halt ? ST_HALT : ST_REQ;
                        if (w_load) begin
                            r_pc <= r_req_pc + XLEN'(PC_INC);
                        end
                    end else begin
                        if (w_redirect) r_drop <= 1'b1;
                        if (bus.halt_req) r_halt_pend <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (!bus.halt_req && bus.resume) r_state <= ST_REQ;
                end
                default: r_state <= ST_IDLE;
            endcase
            // Redirect overrides any sequential pc update in the same cycle.
            if (w_redirect) r_pc <= w_redirect_pc;
        end
    end

    fetch_out_buf #(.XLEN(XLEN)) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_redirect),
        .i_ready (bus.inst_ready),
        .i_data  (bus.imem_rsp_data),
        .i_pc    (r_req_pc),
        .o_valid (w_inst_valid),
        .o_data  (bus.inst_data),
        .o_pc    (bus.inst_pc)
    );

    assign bus.inst_valid     = w_inst_valid;
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.halted         = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against an instruction-stream model.
module tb_fetch_sequencer;

    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_if #(.XLEN(32)) bus ();

    fetch_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_consumed = 0;
    int          rsp_delay = 1;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        fire;
    logic        saw_req;
    logic [31:0] fire_addr;
    logic [31:0] exp_pc;
    logic [31:0] req_log[$];

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    function automatic logic [31:0] log_at(input int k);
        if (req_log.size() > k) return req_log[k];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive imem response, observe handshakes, update model.
    task automatic tick();
        if (pend && pend_cnt == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            if (pend) pend_cnt--;
        end
        #1;
        fire = bus.imem_req_valid && bus.imem_req_ready;
        saw_req = saw_req | bus.imem_req_valid;
        chk("halted_no_req", 32'(bus.halted & bus.imem_req_valid), 32'h0);
        if (fire) begin
            chk("one_outstanding", 32'(pend), 32'h0);
            pend      = 1'b1;
            pend_addr = bus.imem_req_addr;
            pend_cnt  = rsp_delay - 1;
            fire_addr = bus.imem_req_addr;
            req_log.push_back(bus.imem_req_addr);
        end
        if (bus.inst_valid && bus.inst_ready) begin
            chk("consume_pc", bus.inst_pc, exp_pc);
            chk("consume_data", bus.inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end
        if (bus.trap_req) exp_pc = TRAP;
        else if (bus.branch_taken) exp_pc = {bus.branch_target[31:2], 2'b00};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_fire(input string tag);
        fire = 1'b0;
        for (int i = 0; i < 40 && !fire; i++) tick();
        chk(tag, 32'(fire), 32'h1);
    endtask

    task automatic run_until_req(input string tag, input int n);
        for (int i = 0; i < 60 && req_log.size() < n; i++) tick();
        chk(tag, 32'(req_log.size() >= n), 32'h1);
    endtask

    task automatic wait_inst_valid(input string tag);
        for (int i = 0; i < 40 && !bus.inst_valid; i++) tick();
        chk(tag, 32'(bus.inst_valid), 32'h1);
    endtask

    logic [31:0] held_pc, held_data, a;
    int          consumed_before;

    initial begin
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b1;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = '0;
        bus.trap_req       = 1'b0;
        bus.halt_req       = 1'b0;
        bus.resume         = 1'b0;
        saw_req = 1'b0;
        fire = 1'b0;
        fire_addr = '0;
        exp_pc = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst_data", bus.inst_data, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);

        // Sequential fetch from reset vector.
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", 32'(fire), 32'h0);
        tick();
        chk("first_req_cycle2", 32'(fire), 32'h1);
        run_until_req("seq_timeout", 3);
        chk("seq_addr0", log_at(0), 32'h0);
        chk("seq_addr1", log_at(1), 32'h4);
        chk("seq_addr2", log_at(2), 32'h8);

        // Decode backpressure holds the buffer and blocks new requests.
        bus.inst_ready = 1'b0;
        wait_inst_valid("stall_fill");
        held_pc = bus.inst_pc;
        held_data = bus.inst_data;
        saw_req = 1'b0;
        repeat (4) tick();
        chk("stall_no_req", 32'(saw_req), 32'h0);
        chk("stall_pc_held", bus.inst_pc, held_pc);
        chk("stall_data_held", bus.inst_data, held_data);
        bus.inst_ready = 1'b1;
        req_log.delete();
        run_until_req("stall_release", 1);
        chk("stall_next_addr", log_at(0), held_pc + 32'd4);

        // Branch while a fetch is in flight: stale word dropped.
        rsp_delay = 3;
        wait_fire("br_fire");
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_1003;
        tick();
        bus.branch_taken = 1'b0;
        chk("br_flush", 32'(bus.inst_valid), 32'h0);
        rsp_delay = 1;
        req_log.delete();
        run_until_req("br_timeout", 1);
        chk("br_next_addr", log_at(0), 32'h0000_1000);
        wait_inst_valid("br_deliver");
        chk("br_inst_pc", bus.inst_pc, 32'h0000_1000);

        // Trap beats branch; flushes a held instruction.
        bus.inst_ready = 1'b0;
        wait_inst_valid("trap_fill");
        bus.trap_req = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_2000;
        tick();
        bus.trap_req = 1'b0;
        bus.branch_taken = 1'b0;
        chk("trap_flush", 32'(bus.inst_valid), 32'h0);
        bus.inst_ready = 1'b1;
        req_log.delete();
        run_until_req("trap_timeout", 1);
        chk("trap_next_addr", log_at(0), TRAP);

        // Halt during WAIT: response still delivered, then no fetching until resume.
        rsp_delay = 2;
        wait_fire("halt_fire");
        a = fire_addr;
        bus.inst_ready = 1'b0;
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        for (int i = 0; i < 10 && !bus.halted; i++) tick();
        chk("halt_entered", 32'(bus.halted), 32'h1);
        chk("halt_delivered", 32'(bus.inst_valid), 32'h1);
        chk("halt_inst_pc", bus.inst_pc, a);
        saw_req = 1'b0;
        repeat (4) tick();
        chk("halt_no_req", 32'(saw_req), 32'h0);
        bus.inst_ready = 1'b1;
        tick();
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        chk("resume_unhalted", 32'(bus.halted), 32'h0);
        req_log.delete();
        run_until_req("resume_timeout", 1);
        chk("resume_addr", log_at(0), a + 32'd4);

        // PC wraps past the top of the address space.
        rsp_delay = 1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hFFFF_FFFE;
        tick();
        bus.branch_taken = 1'b0;
        req_log.delete();
        run_until_req("wrap_timeout", 2);
        chk("wrap_addr_top", log_at(0), 32'hFFFF_FFFC);
        chk("wrap_addr_zero", log_at(1), 32'h0);

        // Asynchronous reset while a fetch is outstanding.
        rsp_delay = 3;
        wait_fire("arst_fire");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("arst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("arst_inst_data", bus.inst_data, 32'h0);
        chk("arst_inst_pc", bus.inst_pc, 32'h0);
        chk("arst_halted", 32'(bus.halted), 32'h0);
        pend = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h0;
        rsp_delay = 1;
        req_log.delete();
        run_until_req("arst_timeout", 1);
        chk("arst_restart_addr", log_at(0), 32'h0);

        // Randomized traffic checked against the instruction-stream model.
        for (int i = 0; i < 1500; i++) begin
            bus.inst_ready     = ($urandom_range(0, 9) < 7);
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            rsp_delay          = $urandom_range(1, 3);
            bus.branch_taken   = ($urandom_range(0, 99) < 3);
            bus.branch_target  = $urandom;
            bus.trap_req       = ($urandom_range(0, 99) < 1);
            bus.halt_req       = ($urandom_range(0, 99) < 2);
            bus.resume         = ($urandom_range(0, 9) < 2);
            tick();
        end
        bus.branch_taken = 1'b0;
        bus.trap_req = 1'b0;
        bus.halt_req = 1'b0;
        bus.resume = 1'b1;
        bus.inst_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        consumed_before = n_consumed;
        repeat (20) tick();
        chk("rand_progress", 32'(n_consumed > consumed_before), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
